// File: rtl/spi_aes_responder_pkg.sv
// Shared types and constants for the AES SPI responder: FSM state encoding,
// block width, frame length and the result parity helper.
package spi_aes_responder_pkg;

  localparam int BLOCK_BITS = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX    = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_MARK  = 3'd4,
    ST_TX    = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  function automatic int rx_bits(input int nk);
    return BLOCK_BITS + nk * 32;
  endfunction

  function automatic logic parity128(input logic [127:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/spi_aes_responder_shift_reg.sv
// Parameterised load / shift-left register; q[W-1] is the serial output and
// sin enters at the LSB.
module spi_shift_reg #(
  parameter int W = 128
) (
  input  logic         clk_master,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d, data_q;

  // next contents: parallel load wins over shift
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {data_q[W-2:0], sin};
    end else begin
      data_d = data_q;
    end
  end

  // storage with asynchronous clear
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/spi_aes_responder.sv
// SPI target for one AES core: receives {data, key}, runs the core, returns the
// result after a 1-bit start marker. Optional macro: SPI_RSP_PARITY_EN.
module spi_aes_responder
  import spi_aes_responder_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic               clk_master,
  input  logic               rst,
  input  logic               cs,
  input  logic               sdi,
  output logic               sdo,
  output logic [127:0]       core_data,
  output logic [NK*32-1:0]   core_key,
  output logic               core_start,
  input  logic               core_done,
  input  logic [127:0]       core_result,
  output logic               rsp_done
);

  localparam int RX_BITS  = rx_bits(NK);
  localparam int KEY_BITS = NK * 32;
  localparam int CNT_W    = $clog2(RX_BITS + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_BITS - 1);
  localparam logic [CNT_W-1:0] TX_BIT0 = CNT_W'(BLOCK_BITS - 1);
`ifdef SPI_RSP_PARITY_EN
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(BLOCK_BITS);
`else
  localparam logic [CNT_W-1:0] TX_LAST = TX_BIT0;
`endif

  state_e                state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  sdo_d, sdo_q;
  logic                  core_start_d, core_start_q;
  logic                  rsp_done_d, rsp_done_q;
  logic [127:0]          core_data_d, core_data_q;
  logic [KEY_BITS-1:0]   core_key_d, core_key_q;
  logic                  rx_shift, tx_load, tx_shift;
  logic [RX_BITS-1:0]    rx_q, rx_next;
  logic [127:0]          tx_q;
  logic                  parity_bit;

  spi_shift_reg #(.W(RX_BITS)) u_rx (
    .clk_master(clk_master), .rst(rst), .load(1'b0), .shift(rx_shift),
    .sin(sdi), .load_val({RX_BITS{1'b0}}), .q(rx_q)
  );

  spi_shift_reg #(.W(BLOCK_BITS)) u_tx (
    .clk_master(clk_master), .rst(rst), .load(tx_load), .shift(tx_shift),
    .sin(1'b0), .load_val(core_result), .q(tx_q)
  );

  assign rx_next = {rx_q[RX_BITS-2:0], sdi};

`ifdef SPI_RSP_PARITY_EN
  logic parity_d, parity_q;
  // parity of the result is captured when the core hands it over
  always_comb begin
    if (tx_load) begin
      parity_d = parity128(core_result);
    end else begin
      parity_d = parity_q;
    end
  end

  // parity storage
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
  assign parity_bit = parity_q;
`else
  assign parity_bit = 1'b0;
`endif

  // transaction FSM; cs low outside IDLE/DONE falls through to the abort defaults
  always_comb begin
    state_d      = state_q;
    cnt_d        = {CNT_W{1'b0}};
    sdo_d        = 1'b0;
    core_start_d = 1'b0;
    rsp_done_d   = 1'b0;
    core_data_d  = core_data_q;
    core_key_d   = core_key_q;
    rx_shift     = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_RX;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RX: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RX_LAST) begin
          rx_shift     = 1'b1;
          core_data_d  = rx_next[RX_BITS-1 -: BLOCK_BITS];
          core_key_d   = rx_next[KEY_BITS-1:0];
          core_start_d = 1'b1;
          state_d      = ST_START;
        end else begin
          rx_shift = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_START, ST_WAIT: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else if (core_done) begin
          tx_load = 1'b1;
          sdo_d   = 1'b1;
          state_d = ST_MARK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_MARK: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else begin
          sdo_d    = tx_q[127];
          tx_shift = 1'b1;
          state_d  = ST_TX;
        end
      end
      ST_TX: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TX_LAST) begin
          rsp_done_d = 1'b1;
          state_d    = ST_DONE;
        end else if (cnt_q == TX_BIT0) begin
          sdo_d = parity_bit;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          sdo_d    = tx_q[127];
          tx_shift = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else begin
          rsp_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      sdo_q        <= 1'b0;
      core_start_q <= 1'b0;
      rsp_done_q   <= 1'b0;
      core_data_q  <= 128'd0;
      core_key_q   <= {KEY_BITS{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sdo_q        <= sdo_d;
      core_start_q <= core_start_d;
      rsp_done_q   <= rsp_done_d;
      core_data_q  <= core_data_d;
      core_key_q   <= core_key_d;
    end
  end

  assign sdo        = sdo_q;
  assign core_start = core_start_q;
  assign rsp_done   = rsp_done_q;
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;

endmodule
